// File: rtl/button_conditioner.sv
// Per-channel button front end: synchronizer, debounce, press/release edge pulses
// and typematic auto-repeat. Channels share no state.
module button_conditioner #(
  parameter int NUM_BTNS       = 5,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_COUNT = 250_000,
  parameter int REPEAT_DELAY   = 12_500_000,
  parameter int REPEAT_PERIOD  = 2_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_COUNT + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   accept;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   rpt_phase_q, rpt_phase_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level_q) && (dcnt_q == DC_LAST);

    always_comb begin
      dcnt_d      = dcnt_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      repeat_d    = 1'b0;
      rcnt_d      = rcnt_q;
      rpt_phase_d = rpt_phase_q;

      if (s == level_q) begin
        dcnt_d = '0;
      end else if (accept) begin
        dcnt_d    = '0;
        level_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end

      // The release edge counts as "not held", so it also swallows a coincident repeat.
      if (!level_q || accept) begin
        rcnt_d      = '0;
        rpt_phase_d = 1'b0;
      end else if (!rpt_phase_q && rcnt_q == RD_LAST) begin
        repeat_d    = 1'b1;
        rcnt_d      = '0;
        rpt_phase_d = 1'b1;
      end else if (rpt_phase_q && rcnt_q == RP_LAST) begin
        repeat_d = 1'b1;
        rcnt_d   = '0;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q      <= '0;
        dcnt_q      <= '0;
        rcnt_q      <= '0;
        rpt_phase_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
        dcnt_q      <= dcnt_d;
        rcnt_q      <= rcnt_d;
        rpt_phase_q <= rpt_phase_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        repeat_q    <= repeat_d;
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_repeat[gi]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued with
// their edge number at stimulus time and matched against the outputs every cycle.
module tb_button_conditioner;
  localparam int NB = 5;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .NUM_BTNS(NB), .SYNC_STAGES(SS), .DEBOUNCE_COUNT(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 repeat
  } ev_t;

  ev_t           evq[$];
  logic [NB-1:0] lvl_exp = '0;
  bit            mon_en = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
  endtask

  // Expected events for a clean hold: raw rises after edge t_rise, drops after edge t_drop.
  function automatic void push_hold(input int ch, input int t_rise, input int t_drop);
    int p = t_rise + SS + DC;
    int r = t_drop + SS + DC;
    int t = p + RD;
    evq.push_back(ev_t'{p, ch, 0});
    while (t < r) begin
      evq.push_back(ev_t'{t, ch, 2});
      t += RP;
    end
    evq.push_back(ev_t'{r, ch, 1});
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    logic [NB-1:0] ep, er, et;
    if (mon_en && rst_n) begin
      ep = '0; er = '0; et = '0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc == cyc) begin
          case (evq[i].kind)
            0: ep[evq[i].ch] = 1'b1;
            1: er[evq[i].ch] = 1'b1;
            default: et[evq[i].ch] = 1'b1;
          endcase
          $display("txn edge %0d ch %0d kind %0d", cyc, evq[i].ch, evq[i].kind);
          evq.delete(i);
        end else if (evq[i].cyc < cyc) begin
          check("stale_event", evq[i].cyc, cyc);
          evq.delete(i);
        end
      end
      lvl_exp = (lvl_exp | ep) & ~er;
      check("press",   btn_press,   ep);
      check("release", btn_release, er);
      check("repeat",  btn_repeat,  et);
      check("level",   btn_level,   lvl_exp);
    end
  end

  initial begin
    int t;
    // Reset held with random inputs: everything stays at zero.
    for (int i = 0; i < 20; i++) begin
      btn_raw = NB'($urandom_range(0, (1 << NB) - 1));
      @(negedge clk);
      check("rst_level",   btn_level,   0);
      check("rst_press",   btn_press,   0);
      check("rst_release", btn_release, 0);
      check("rst_repeat",  btn_repeat,  0);
    end
    btn_raw = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_cyc(5);

    $display("txn clean press/release ch0 at edge %0d", cyc);
    push_hold(0, cyc, cyc + 30);
    btn_raw[0] = 1'b1;
    wait_cyc(30);
    btn_raw[0] = 1'b0;
    wait_cyc(12);

    $display("txn bounce ch1 at edge %0d", cyc);
    repeat (5) begin
      btn_raw[1] = 1'b1; wait_cyc(3);
      btn_raw[1] = 1'b0; wait_cyc(1);
    end
    push_hold(1, cyc, cyc + 20);
    btn_raw[1] = 1'b1;
    wait_cyc(20);
    btn_raw[1] = 1'b0;
    wait_cyc(12);

    $display("txn simultaneous ch2/ch3 with ch4 glitch at edge %0d", cyc);
    t = cyc;
    push_hold(2, t, t + 15);
    push_hold(3, t, t + 15);
    btn_raw[4:2] = 3'b111;
    wait_cyc(2);
    btn_raw[4] = 1'b0;
    wait_cyc(13);
    btn_raw[3:2] = 2'b00;
    wait_cyc(12);

    // Release accepted exactly on the second repeat's edge.
    $display("txn release at repeat boundary ch0 at edge %0d", cyc);
    push_hold(0, cyc, cyc + 13);
    btn_raw[0] = 1'b1;
    wait_cyc(13);
    btn_raw[0] = 1'b0;
    wait_cyc(12);

    $display("txn reset mid-operation ch0 at edge %0d", cyc);
    t = cyc;
    evq.push_back(ev_t'{t + SS + DC, 0, 0});
    btn_raw[0] = 1'b1;
    wait_cyc(8);
    #2 rst_n = 1'b0;
    #1;
    check("async_level",   btn_level,   0);
    check("async_press",   btn_press,   0);
    check("async_release", btn_release, 0);
    check("async_repeat",  btn_repeat,  0);
    evq.delete();
    lvl_exp = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    push_hold(0, cyc, cyc + 20);
    wait_cyc(20);
    btn_raw[0] = 1'b0;
    wait_cyc(12);

    check("queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning stage between the board push-buttons and the movement/position logic of the VGA demos. Each of `NUM_BTNS` raw asynchronous button inputs is synchronized into the `clk` domain and debounced. Each channel then produces a clean level, one-cycle press and release pulses, and a typematic auto-repeat pulse. Downstream position logic consumes `btn_level` for held-button motion or `btn_press`/`btn_repeat` for step motion.

## Interface
- `NUM_BTNS`, 5: number of independent button channels (bit order up, down, left, right, center at default).
- `SYNC_STAGES`, 2: synchronizer flops per input, ≥2.
- `DEBOUNCE_COUNT`, 250_000: consecutive disagreeing cycles required to accept a new level (10 ms at 25 MHz), ≥1.
- `REPEAT_DELAY`, 12_500_000: cycles from accepted press to first repeat pulse, ≥1.
- `REPEAT_PERIOD`, 2_500_000: cycles between subsequent repeat pulses, ≥1.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `btn_raw`  in  NUM_BTNS  raw button pins, active-high, asynchronous to `clk`.
- `btn_level`  out  NUM_BTNS  debounced level, registered.
- `btn_press`  out  NUM_BTNS  one-cycle pulse on each accepted 0→1 transition.
- `btn_release`  out  NUM_BTNS  one-cycle pulse on each accepted 1→0 transition.
- `btn_repeat`  out  NUM_BTNS  one-cycle auto-repeat pulse while held.

## Operation
- Channels are fully independent; there is no shared state and no priority between them.
- Synchronizer: `SYNC_STAGES`-deep flop chain per bit. `s` is the last stage.
- Debounce counter `dcnt`, width clog2(DEBOUNCE_COUNT+1), evaluated per edge:
  - `s == btn_level`: `dcnt` <= 0.
  - `s != btn_level` and `dcnt == DEBOUNCE_COUNT-1`: `btn_level` <= `s`, `dcnt` <= 0, and `btn_press` (if `s`=1) or `btn_release` (if `s`=0) <= 1 for exactly that cycle.
  - Otherwise: `dcnt` <= `dcnt` + 1.
- Any glitch shorter than `DEBOUNCE_COUNT` synchronized cycles clears `dcnt` and produces no output change. The count never wraps.
- Repeat counter `rcnt` (width clog2 of max(REPEAT_DELAY, REPEAT_PERIOD)+1) and flag `rpt_phase`:
  - On the accepted-press edge: `rcnt` <= 0, `rpt_phase` <= 0.
  - While `btn_level`=1: `rcnt` increments each cycle.
    - When `rpt_phase`=0 and `rcnt == REPEAT_DELAY-1`: `btn_repeat` pulses, `rcnt` <= 0, `rpt_phase` <= 1.
    - When `rpt_phase`=1 and `rcnt == REPEAT_PERIOD-1`: `btn_repeat` pulses, `rcnt` <= 0.
  - While `btn_level`=0 (including the release edge): `rcnt` <= 0, `rpt_phase` <= 0, and no repeat pulse. A release in the same cycle a repeat would fire suppresses that repeat.
- `btn_press` and `btn_repeat` never assert in the same cycle on one channel.
- Reset (asynchronous assert, any time, including mid-count): synchronizer flops, `dcnt`, `rcnt`, `rpt_phase`, and all outputs go to 0. A button held through reset is re-accepted as a fresh press after the normal debounce time.

## Timing
- All outputs are registered with no combinational path from `btn_raw`.
- Let edge 1 be the first `clk` edge that samples a new stable `btn_raw` value.
  - `btn_level` and the press/release pulse change at edge `SYNC_STAGES + DEBOUNCE_COUNT`. At defaults that is edge 250_002.
- First `btn_repeat` occurs `REPEAT_DELAY` edges after the press pulse edge. Subsequent pulses occur every `REPEAT_PERIOD` edges.
- Pulses are high for exactly one `clk` cycle.
- Throughput: a channel can accept a new transition every `DEBOUNCE_COUNT` cycles.

## Test plan
Run with SYNC_STAGES=2, DEBOUNCE_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTNS=5.
- **Clean press and release:** raise `btn_raw[0]`, hold 30 cycles, then drop and hold.
  - `btn_level[0]` rises at edge 6 with `btn_press[0]` high that cycle only.
  - `btn_repeat[0]` pulses at edges 16, 19, 22, …
  - After the drop, `btn_level[0]` falls 6 edges later with a single `btn_release[0]` pulse and no further repeats.
- **Bounce rejection:** toggle `btn_raw[1]` high 3 cycles / low 1 cycle, repeated 5×, then hold high.
  - No press during bouncing.
  - Exactly one `btn_press[1]` 6 edges after the final rising edge.
- **Simultaneous channels:** raise bits 2 and 3 on the same edge and pulse bit 4 for 2 cycles.
  - `btn_press[2]` and `btn_press[3]` fire together at edge 6.
  - Bit 4 produces no output.
- **Release at repeat boundary:** press `btn_raw[0]`, then drop it so the accepted release lands on the edge a repeat would fire.
  - `btn_release[0]` pulses and `btn_repeat[0]` does not.
- **Reset mid-operation:** assert `rst_n`=0 for 1 cycle while `btn_level[0]`=1 and `btn_raw[0]` is still held.
  - All outputs read 0 immediately (asynchronously).
  - After deassert, `btn_press[0]` re-fires 6 edges later.
- **Reset values:** hold `rst_n`=0 with random `btn_raw` → all outputs remain 0 throughout.
